// File: rtl/adf_freq_ctrl.sv
// Front-panel frequency controller for the ADF4351: turns debounced key pulses into a
// saturating MHz target and hands every new value to the register writer via req/ack.
module adf_freq_ctrl #(
    parameter int FREQ_W    = 16,
    parameter int FREQ_MIN  = 35,
    parameter int FREQ_MAX  = 4400,
    parameter int FREQ_INIT = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              k_up,
    input  logic              k_dn,
    input  logic              k_step,
    input  logic              load_ack,
    output logic [FREQ_W-1:0] freq,
    output logic [1:0]        step_sel,
    output logic              load_req,
    output logic              busy
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_REQ, S_DONE} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_UP, EV_DN, EV_STEP} ev_t;

    localparam logic [FREQ_W:0]   MIN_W  = (FREQ_W+1)'(FREQ_MIN);
    localparam logic [FREQ_W:0]   MAX_W  = (FREQ_W+1)'(FREQ_MAX);
    localparam logic [FREQ_W-1:0] FMIN   = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0] FMAX   = FREQ_W'(FREQ_MAX);
    localparam logic [FREQ_W-1:0] FINIT  = FREQ_W'(FREQ_INIT);

    state_t            state_q, state_d;
    ev_t               pend_q, pend_d;
    ev_t               ev_in, ev;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [1:0]        step_q, step_d;
    logic              load_req_q, load_req_d;

    logic [FREQ_W:0]   step_tab [4];
    logic [FREQ_W:0]   step_w;
    logic [FREQ_W:0]   sum_w;
    logic [FREQ_W-1:0] up_nxt, dn_nxt, nxt;

    // Step sizes are decades: 1, 10, 100, 1000 MHz.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_step
            assign step_tab[gi] = (FREQ_W+1)'(10 ** gi);
        end
    endgenerate

    // Arithmetic is one bit wider than freq so neither direction can wrap.
    always_comb begin
        step_w = step_tab[step_q];
        sum_w  = {1'b0, freq_q} + step_w;
        up_nxt = (sum_w > MAX_W) ? FMAX : sum_w[FREQ_W-1:0];
        dn_nxt = ({1'b0, freq_q} < (MIN_W + step_w)) ? FMIN
                                                     : (freq_q - step_w[FREQ_W-1:0]);
    end

    always_comb begin
        if (k_up)        ev_in = EV_UP;
        else if (k_dn)   ev_in = EV_DN;
        else if (k_step) ev_in = EV_STEP;
        else             ev_in = EV_NONE;
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        freq_d     = freq_q;
        step_d     = step_q;
        load_req_d = load_req_q;
        ev         = EV_NONE;
        nxt        = freq_q;
        case (state_q)
            S_INIT: begin
                if (ev_in != EV_NONE) pend_d = ev_in;
                load_req_d = 1'b1;
                state_d    = S_REQ;
            end
            S_IDLE: begin
                // A fresh pulse is newer than anything deferred, so it wins.
                ev     = (ev_in != EV_NONE) ? ev_in : pend_q;
                pend_d = EV_NONE;
                case (ev)
                    EV_UP:   nxt = up_nxt;
                    EV_DN:   nxt = dn_nxt;
                    EV_STEP: step_d = 2'(step_q + 2'd1);
                    default: ;
                endcase
                if ((ev == EV_UP || ev == EV_DN) && nxt != freq_q) begin
                    freq_d     = nxt;
                    load_req_d = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (ev_in != EV_NONE) pend_d = ev_in;
                if (load_ack) begin
                    load_req_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (ev_in != EV_NONE) pend_d = ev_in;
                // A level ack must drop before the next request can be counted.
                if (!load_ack) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT;
            pend_q     <= EV_NONE;
            freq_q     <= FINIT;
            step_q     <= 2'd0;
            load_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            freq_q     <= freq_d;
            step_q     <= step_d;
            load_req_q <= load_req_d;
        end
    end

    assign freq     = freq_q;
    assign step_sel = step_q;
    assign load_req = load_req_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_adf_freq_ctrl.sv
// Scoreboard bench for adf_freq_ctrl: expected frequencies are queued when keys are
// pressed and popped when the controller raises load_req.
module tb_adf_freq_ctrl;

    logic        clk;
    logic        rst;
    logic        k_up, k_dn, k_step, load_ack;
    logic [15:0] freq;
    logic [1:0]  step_sel;
    logic        load_req;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          req_count = 0;
    logic        lr_prev = 1'b0;
    int          exp_q[$];
    int          model_freq;
    int          base;
    int          exp_v;
    logic [15:0] f_obs;
    bit          ok;

    adf_freq_ctrl #(
        .FREQ_W(16), .FREQ_MIN(35), .FREQ_MAX(4400), .FREQ_INIT(100)
    ) dut (
        .clk(clk), .rst(rst), .k_up(k_up), .k_dn(k_dn), .k_step(k_step),
        .load_ack(load_ack), .freq(freq), .step_sel(step_sel),
        .load_req(load_req), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count request rising edges, sampled mid-cycle.
    always @(negedge clk) begin
        if (load_req && !lr_prev) req_count++;
        lr_prev = load_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit u, input bit d, input bit s);
        k_up = u; k_dn = d; k_step = s;
        tick();
        k_up = 1'b0; k_dn = 1'b0; k_step = 1'b0;
    endtask

    // Wait (bounded) for a request, ack it after 'delay' cycles, hold ack 'hold' cycles.
    task automatic serve(input int delay, input int hold, output logic [15:0] f, output bit got);
        for (int i = 0; i < 40; i++) begin
            if (load_req) break;
            tick();
        end
        got = load_req;
        f   = freq;
        $display("txn: req freq=%0d step_sel=%0d got=%0d t=%0t", freq, step_sel, got, $time);
        repeat (delay) tick();
        load_ack = 1'b1;
        repeat (hold) tick();
        load_ack = 1'b0;
        tick();
    endtask

    task automatic do_reset(output logic [15:0] f, output bit got);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        serve(1, 1, f, got);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (freq !== 16'd100) begin n_bad++; $display("FAIL rst_freq: got %0d want 100", freq); end
        n_cmp++; if (step_sel !== 2'd0) begin n_bad++; $display("FAIL rst_step: got %0d want 0", step_sel); end
        n_cmp++; if (load_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %0b want 0", load_req); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %0b want 1", busy); end
        rst = 1'b0;
        exp_q.push_back(100);
        tick();
        n_cmp++; if (load_req !== 1'b1) begin n_bad++; $display("FAIL init_req: got %0b want 1", load_req); end
        f_obs = freq;
        $display("txn: req freq=%0d step_sel=%0d t=%0t", freq, step_sel, $time);
        repeat (3) tick();
        n_cmp++; if (load_req !== 1'b1) begin n_bad++; $display("FAIL init_hold: got %0b want 1", load_req); end
        load_ack = 1'b1;
        tick();
        n_cmp++; if (load_req !== 1'b0) begin n_bad++; $display("FAIL init_drop: got %0b want 0", load_req); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL init_done_busy: got %0b want 1", busy); end
        load_ack = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL init_idle: got %0b want 0", busy); end
        exp_v = exp_q.pop_front();
        n_cmp++; if (int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL init_freq: got %0d want %0d", f_obs, exp_v); end
        repeat (4) tick();
        n_cmp++; if (req_count !== 1) begin n_bad++; $display("FAIL init_count: got %0d want 1", req_count); end
        model_freq = 100;
    endtask

    task automatic test_step_up();
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++; if (step_sel !== 2'd1) begin n_bad++; $display("FAIL step1: got %0d want 1", step_sel); end
        n_cmp++; if (load_req !== 1'b0) begin n_bad++; $display("FAIL step_noreq: got %0b want 0", load_req); end
        model_freq += 10;
        exp_q.push_back(model_freq);
        pulse(1'b1, 1'b0, 1'b0);
        n_cmp++; if (load_req !== 1'b1) begin n_bad++; $display("FAIL up_latency: got %0b want 1", load_req); end
        n_cmp++; if (freq !== 16'd110) begin n_bad++; $display("FAIL up_freq: got %0d want 110", freq); end
        serve(2, 1, f_obs, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL up10: got %0d ok=%0b want %0d", f_obs, ok, exp_v); end
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++; if (step_sel !== 2'd3) begin n_bad++; $display("FAIL step3: got %0d want 3", step_sel); end
        for (int i = 0; i < 5; i++) begin
            model_freq = (model_freq + 1000 > 4400) ? 4400 : model_freq + 1000;
            exp_q.push_back(model_freq);
            pulse(1'b1, 1'b0, 1'b0);
            serve(1, 1, f_obs, ok);
            exp_v = exp_q.pop_front();
            n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL up1000_%0d: got %0d ok=%0b want %0d", i, f_obs, ok, exp_v); end
        end
        base = req_count;
        pulse(1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        n_cmp++; if (req_count !== base) begin n_bad++; $display("FAIL sat_hi_noreq: got %0d reqs want %0d", req_count, base); end
        n_cmp++; if (freq !== 16'd4400) begin n_bad++; $display("FAIL sat_hi_freq: got %0d want 4400", freq); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sat_hi_busy: got %0b want 0", busy); end
    endtask

    task automatic test_sat_low();
        exp_q.push_back(100);
        do_reset(f_obs, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL lo_reset: got %0d ok=%0b want %0d", f_obs, ok, exp_v); end
        model_freq = 100;
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            model_freq = (model_freq < 35 + 10) ? 35 : model_freq - 10;
            exp_q.push_back(model_freq);
            pulse(1'b0, 1'b1, 1'b0);
            serve(0, 1, f_obs, ok);
            exp_v = exp_q.pop_front();
            n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL dn10_%0d: got %0d ok=%0b want %0d", i, f_obs, ok, exp_v); end
        end
        base = req_count;
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        n_cmp++; if (req_count !== base) begin n_bad++; $display("FAIL sat_lo_noreq: got %0d reqs want %0d", req_count, base); end
        repeat (3) pulse(1'b0, 1'b0, 1'b1);
        n_cmp++; if (step_sel !== 2'd0) begin n_bad++; $display("FAIL step_wrap: got %0d want 0", step_sel); end
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        n_cmp++; if (req_count !== base) begin n_bad++; $display("FAIL sat_lo1_noreq: got %0d reqs want %0d", req_count, base); end
        n_cmp++; if (freq !== 16'd35) begin n_bad++; $display("FAIL sat_lo_freq: got %0d want 35", freq); end
    endtask

    task automatic test_priority();
        exp_q.push_back(100);
        do_reset(f_obs, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL pri_reset: got %0d ok=%0b want %0d", f_obs, ok, exp_v); end
        exp_q.push_back(101);
        pulse(1'b1, 1'b1, 1'b0);
        serve(1, 1, f_obs, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL pri_updn: got %0d ok=%0b want %0d", f_obs, ok, exp_v); end
        exp_q.push_back(100);
        do_reset(f_obs, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL pri_reset2: got %0d ok=%0b want %0d", f_obs, ok, exp_v); end
        exp_q.push_back(101);
        pulse(1'b1, 1'b0, 1'b1);
        serve(1, 1, f_obs, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL pri_upstep: got %0d ok=%0b want %0d", f_obs, ok, exp_v); end
        n_cmp++; if (step_sel !== 2'd0) begin n_bad++; $display("FAIL pri_step_kept: got %0d want 0", step_sel); end
        model_freq = 101;
    endtask

    task automatic test_pending();
        base = req_count;
        exp_q.push_back(model_freq + 1);
        pulse(1'b1, 1'b0, 1'b0);
        tick();
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        n_cmp++; if (freq !== 16'(model_freq + 1)) begin n_bad++; $display("FAIL pend_hold: got %0d want %0d", freq, model_freq + 1); end
        n_cmp++; if (load_req !== 1'b1) begin n_bad++; $display("FAIL pend_req: got %0b want 1", load_req); end
        exp_q.push_back(model_freq + 2);
        serve(0, 3, f_obs, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL pend_first: got %0d ok=%0b want %0d", f_obs, ok, exp_v); end
        serve(1, 1, f_obs, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL pend_second: got %0d ok=%0b want %0d", f_obs, ok, exp_v); end
        repeat (4) tick();
        n_cmp++; if (req_count - base !== 2) begin n_bad++; $display("FAIL pend_count: got %0d want 2", req_count - base); end
        model_freq += 2;
    endtask

    task automatic test_reset_mid();
        repeat (3) pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            model_freq = (model_freq + 1000 > 4400) ? 4400 : model_freq + 1000;
            exp_q.push_back(model_freq);
            pulse(1'b1, 1'b0, 1'b0);
            if (model_freq < 4400) begin
                serve(1, 1, f_obs, ok);
                exp_v = exp_q.pop_front();
                n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL mid_up_%0d: got %0d ok=%0b want %0d", i, f_obs, ok, exp_v); end
            end
        end
        exp_v = exp_q.pop_front();
        n_cmp++; if (load_req !== 1'b1 || int'(freq) !== exp_v) begin n_bad++; $display("FAIL mid_pre: got req=%0b freq=%0d want req=1 freq=%0d", load_req, freq, exp_v); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (load_req !== 1'b0) begin n_bad++; $display("FAIL mid_async_req: got %0b want 0", load_req); end
        n_cmp++; if (freq !== 16'd100) begin n_bad++; $display("FAIL mid_async_freq: got %0d want 100", freq); end
        n_cmp++; if (busy !== 1'b1 || step_sel !== 2'd0) begin n_bad++; $display("FAIL mid_async_state: got busy=%0b step=%0d want busy=1 step=0", busy, step_sel); end
        tick();
        base = req_count;
        rst = 1'b0;
        exp_q.push_back(100);
        serve(2, 1, f_obs, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || int'(f_obs) !== exp_v) begin n_bad++; $display("FAIL mid_reload: got %0d ok=%0b want %0d", f_obs, ok, exp_v); end
        repeat (4) tick();
        n_cmp++; if (req_count - base !== 1) begin n_bad++; $display("FAIL mid_count: got %0d want 1", req_count - base); end
    endtask

    initial begin
        rst = 1'b1; k_up = 1'b0; k_dn = 1'b0; k_step = 1'b0; load_ack = 1'b0;
        test_reset();
        test_step_up();
        test_sat_low();
        test_priority();
        test_pending();
        test_reset_mid();
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
